// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: preset -> 0 on enabled ticks, one-tick done pulse on expiry.
// Latency: start in IDLE enters RUN on that tick, first decrement on the next enabled tick; done P+1 ticks after start.
// Backpressure: none; en=0 freezes all state, and load/start/pause are ignored while en=0.
// Optional feature: define DOWN_CNT_AUTORELOAD_EN to restart from the reload register after each expiry.
module down_counter_timer #(
    parameter int BITS = 4
) (
    input  logic            clk_buff,
    input  logic            rst,
    input  logic            en,
    input  logic            load,
    input  logic            start,
    input  logic            pause,
    input  logic [BITS-1:0] preset,
    output logic [BITS-1:0] Out,
    output logic            busy,
    output logic            done,
    output logic            zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [BITS-1:0] ONE = {{(BITS-1){1'b0}}, 1'b1};

    state_t          r_state;
    logic [BITS-1:0] r_out;
    logic [BITS-1:0] r_reload;
    logic            r_busy;
    logic            r_done;

    // State, count, reload and Moore outputs all advance together on enabled ticks.
    always_ff @(posedge clk_buff or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_out    <= '0;
            r_reload <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (en) begin
            if (load) begin
                // load outranks everything: aborts RUN/HOLD and swallows a pending DONE
                r_out    <= preset;
                r_reload <= preset;
                r_state  <= S_IDLE;
                r_busy   <= 1'b0;
                r_done   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // pause outranks start, and a zero count has nothing to time
                        if (start && !pause && (r_out != '0)) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            r_state <= S_HOLD;
                        end else if (r_out <= ONE) begin
                            // last step; clamps at zero so the count never wraps
                            r_out   <= '0;
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_out <= r_out - ONE;
                        end
                    end
                    S_HOLD: begin
                        if (start && !pause) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        r_done <= 1'b0;
`ifdef DOWN_CNT_AUTORELOAD_EN
                        // periodic mode: restart unless paused or nothing to reload
                        if (!pause && (r_reload != '0)) begin
                            r_out   <= r_reload;
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_out   <= '0;
                            r_state <= S_IDLE;
                        end
`else
                        r_out   <= '0;
                        r_state <= S_IDLE;
`endif
                    end
                    default: begin
                        r_out   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Out  = r_out;
    assign busy = r_busy;
    assign done = r_done;
    // zero is deliberately combinational so it tracks Out with no extra tick
    assign zero = (r_out == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer (default build, auto-reload disabled).
// Vector table covers countdown, pause/resume, enable, priority and load-over-DONE; hand sequences cover reset and the 15 boundary.
// Inputs are driven on the falling edge and outputs checked on the following falling edge.
module tb_down_counter_timer;

    logic       clk_buff = 1'b0;
    logic       rst      = 1'b0;
    logic       en       = 1'b0;
    logic       load     = 1'b0;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic [3:0] preset   = 4'd0;
    logic [3:0] Out;
    logic       busy;
    logic       done;
    logic       zero;

    int errors = 0;
    int checks = 0;

    down_counter_timer #(.BITS(4)) dut (
        .clk_buff (clk_buff),
        .rst      (rst),
        .en       (en),
        .load     (load),
        .start    (start),
        .pause    (pause),
        .preset   (preset),
        .Out      (Out),
        .busy     (busy),
        .done     (done),
        .zero     (zero)
    );

    always #5 clk_buff = ~clk_buff;

    typedef struct {
        logic       en;
        logic       load;
        logic       start;
        logic       pause;
        logic [3:0] preset;
        logic [3:0] out;
        logic       busy;
        logic       done;
        logic       zero;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic e, logic l, logic s, logic p, logic [3:0] pr,
                                logic [3:0] o, logic b, logic d, logic z);
        vec_t v;
        v.en = e; v.load = l; v.start = s; v.pause = p; v.preset = pr;
        v.out = o; v.busy = b; v.done = d; v.zero = z;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] o, input logic b,
                           input logic d, input logic z);
        chk({tag, ".Out"},  Out,          o);
        chk({tag, ".busy"}, {3'b0, busy}, {3'b0, b});
        chk({tag, ".done"}, {3'b0, done}, {3'b0, d});
        chk({tag, ".zero"}, {3'b0, zero}, {3'b0, z});
    endtask

    // drive on negedge, let one rising edge happen, land on the next negedge
    task automatic tick(input logic e, input logic l, input logic s, input logic p,
                        input logic [3:0] pr);
        en = e; load = l; start = s; pause = p; preset = pr;
        @(posedge clk_buff);
        @(negedge clk_buff);
    endtask

    initial begin
        // ---------------- vector table ----------------
        //                  en ld st pa pre  Out busy done zero
        // basic countdown: 3,3,2,1,0 then DONE then IDLE
        vq.push_back(mk(1, 1, 0, 0, 4'd3, 4'd3, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd3, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1));
        // start with Out=0 is ignored
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd0, 0, 0, 1));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1));
        // pause/resume: load 6, run to 4, pause 3 ticks, resume
        vq.push_back(mk(1, 1, 0, 0, 4'd6, 4'd6, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd6, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd5, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 1, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 1, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 1, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1));
        // pause+start in HOLD stays in HOLD
        vq.push_back(mk(1, 1, 0, 0, 4'd4, 4'd4, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 1, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 1, 1, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd4, 1, 0, 0));
        // resume, then en=0 for 4 ticks with load asserted: everything holds
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd4, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd3, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 4'd9, 4'd3, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 4'd9, 4'd3, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 4'd9, 4'd3, 1, 0, 0));
        vq.push_back(mk(0, 1, 0, 0, 4'd9, 4'd3, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0));
        // load beats start/pause in RUN: Out=9, IDLE (no decrement next tick)
        vq.push_back(mk(1, 1, 1, 1, 4'd9, 4'd9, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd9, 0, 0, 0));
        // en=0 while in DONE stretches done
        vq.push_back(mk(1, 1, 0, 0, 4'd1, 4'd1, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1));
        vq.push_back(mk(0, 0, 0, 0, 4'd0, 4'd0, 0, 1, 1));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd0, 0, 0, 1));
        // load on the final RUN tick suppresses DONE
        vq.push_back(mk(1, 1, 0, 0, 4'd2, 4'd2, 0, 0, 0));
        vq.push_back(mk(1, 0, 1, 0, 4'd0, 4'd2, 1, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd1, 1, 0, 0));
        vq.push_back(mk(1, 1, 0, 0, 4'd5, 4'd5, 0, 0, 0));
        vq.push_back(mk(1, 0, 0, 0, 4'd0, 4'd5, 0, 0, 0));

        // ---------------- reset state ----------------
        @(negedge clk_buff);
        @(negedge clk_buff);
        chk_all("reset", 4'd0, 0, 0, 1);
        rst = 1'b1;
        @(negedge clk_buff);

        // ---------------- table loop ----------------
        foreach (vq[i]) begin
            tick(vq[i].en, vq[i].load, vq[i].start, vq[i].pause, vq[i].preset);
            chk_all($sformatf("vec%0d", i), vq[i].out, vq[i].busy, vq[i].done, vq[i].zero);
        end

        // ---------------- boundary: preset 15 ----------------
        tick(1, 1, 0, 0, 4'd15);
        chk_all("b15.load", 4'd15, 0, 0, 0);
        tick(1, 0, 1, 0, 4'd0);
        chk_all("b15.start", 4'd15, 1, 0, 0);
        for (int k = 1; k <= 15; k++) begin
            tick(1, 0, 0, 0, 4'd0);
            chk_all($sformatf("b15.t%0d", k), 4'(15 - k), (k < 15), (k == 15), (k == 15));
        end
        tick(1, 0, 0, 0, 4'd0);
        chk_all("b15.nowrap", 4'd0, 0, 0, 1);

        // ---------------- asynchronous reset mid-RUN ----------------
        tick(1, 1, 0, 0, 4'd5);
        tick(1, 0, 1, 0, 4'd0);
        tick(1, 0, 0, 0, 4'd0);
        tick(1, 0, 0, 0, 4'd0);
        chk_all("rr.pre", 4'd3, 1, 0, 0);
        rst = 1'b0;
        #1;
        chk_all("rr.async", 4'd0, 0, 0, 1);
        @(negedge clk_buff);
        rst = 1'b1;
        tick(1, 0, 0, 0, 4'd0);
        chk_all("rr.idle", 4'd0, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down-counter timer with start/pause control, the countdown companion to the team's up-counter. It runs on the divided clock `clk_buff`, counts a preset value down to zero one step per enabled tick, and emits a one-tick `done` pulse on expiry. It drives LEDs or a 7-segment decoder on the DE10-Lite, like the up-counter does.

## Interface
- `BITS`, 4: width of the count, preset and reload registers.
- `clk_buff`  input  1  divided system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `en`  input  1  tick enable. While 0, state, `Out` and the reload register hold, and `load`/`start`/`pause` are ignored.
- `load`  input  1  level-sampled. Copies `preset` into `Out` and into the reload register.
- `start`  input  1  level-sampled. Begins or resumes counting.
- `pause`  input  1  level-sampled. Suspends counting.
- `preset`  input  BITS  value captured by `load`.
- `Out`  output  BITS  current count, registered.
- `busy`  output  1  registered; 1 in RUN or HOLD.
- `done`  output  1  registered; 1 only in DONE.
- `zero`  output  1  combinational, `Out == 0`.

## Operation
- States: IDLE, RUN, HOLD, DONE.
- Reset values: state IDLE, `Out`=0, reload register=0, `busy`=0, `done`=0, `zero`=1.
- Command priority within one enabled tick: `load` > `pause` > `start`.
- `load` in any state:
  - `Out`←`preset`, reload←`preset`, next state IDLE.
  - Aborts a RUN or HOLD.
  - Suppresses a pending DONE.
- IDLE:
  - `start` with `Out`≠0 → RUN. No decrement on this tick.
  - `start` with `Out`=0 is ignored; state stays IDLE.
- RUN, per enabled tick:
  - `pause` → HOLD, `Out` unchanged.
  - Otherwise `Out`←`Out`−1.
  - If `Out` was 1, `Out` becomes 0 and next state is DONE.
  - `Out` never wraps below 0.
- HOLD:
  - `Out` frozen.
  - `start` (with `pause` low) → RUN.
  - `pause` and `start` both high → stay in HOLD.
- DONE:
  - Lasts exactly one enabled tick.
  - Default next state is IDLE with `Out`=0.
  - See Configuration for the auto-reload variant.
- Arithmetic: `BITS`-bit unsigned. The largest preset, 2^BITS−1, takes 2^BITS−1 RUN ticks.
- Asynchronous reset at any time, including mid-RUN or in DONE, forces the reset values immediately. No `done` pulse is emitted.

## Timing
- Latency from `start` sampled in IDLE to first decrement: 2 enabled ticks.
  - Tick N: enter RUN.
  - Tick N+1: `Out` decrements.
- From `start` to `done`=1 with preset P: P+1 enabled ticks after the start edge. `done` is high during the tick following the last decrement.
- `done` is high for exactly one `clk_buff` period if `en` stays 1. If `en`=0 while in DONE, `done` stays high until the next enabled tick.
- `busy` and `done` are Moore outputs and are mutually exclusive.
- `zero` follows `Out` combinationally, with no extra delay.
- Inputs are sampled only on enabled rising edges. The block adds no synchronizers; the caller provides them.

## Configuration
- Macro `DOWN_CNT_AUTORELOAD_EN`.
- Defined: DONE → RUN with `Out`←reload register, giving periodic expiry every P+1 ticks until `pause`, `load` or reset.
  - If the reload register is 0, DONE → IDLE.
  - `busy`=0 during the DONE tick.
- Undefined: DONE → IDLE, `Out` stays 0, and the reload register is still written by `load`.

## Test plan
- Reset mid-RUN: load 5, start, run 2 ticks, assert `rst`=0 → `Out`=0, `busy`=0, `done`=0 immediately, state IDLE.
- Basic countdown (macro off): load 3, start → `Out` sequence 3,3,2,1,0, `done`=1 for one tick, then IDLE with `Out`=0 and `zero`=1.
- Pause/resume: load 6, start, after `Out`=4 assert `pause` for 3 ticks → `Out` holds 4 and `busy`=1. Then `start` → `Out` goes 3,2,1,0, then DONE.
- Priority and enable:
  - `load`=1 with preset 9 and `start`=1 in RUN → `Out`=9, state IDLE.
  - `en`=0 for 4 ticks mid-RUN → `Out` unchanged.
  - `start` with `Out`=0 in IDLE → no transition.
- Boundary with `BITS`=4: load 15, start → 15 decrements, `done` on tick 16 after start, no wrap to 15.
- Auto-reload (macro on): load 2, start → `Out` 2,1,0,2,1,0…, with `done` pulses 3 ticks apart until `pause`.
